// File: rtl/game_state_ctrl.sv
// -----------------------------------------------------------------------------
// game_state_ctrl
//
// Game-flow controller that sits in front of the VGA top. It latches
// per-pixel collisions for each frame and runs the DEAD / GRACE / PLAY state
// machine on frame boundaries. It pulses a one-cycle round reset when a new
// round starts, and keeps a 4-digit BCD score and high score for the overlay.
//
// Ports:
//   i_clk         board clock
//   i_rst_n       asynchronous, active-low reset
//   i_animate     one-cycle frame-end strobe
//   i_collision   per-pixel dino/obstacle overlap (same clock domain)
//   i_start_btn   raw start/jump button, asynchronous to i_clk
//   o_game_state  current state encoding (DEAD_STATE/GRACE_STATE/PLAY_STATE)
//   o_round_rst   one-cycle pulse on the first GRACE cycle of a new round
//   o_score       current score, 4 BCD digits, [15:12] most significant
//   o_high_score  best score since reset, BCD
// -----------------------------------------------------------------------------
module game_state_ctrl #(
    parameter logic [1:0]  DEAD_STATE   = 2'd0,
    parameter logic [1:0]  GRACE_STATE  = 2'd1,
    parameter logic [1:0]  PLAY_STATE   = 2'd2,
    parameter int unsigned GRACE_FRAMES = 120,   // 1..255
    parameter int unsigned DEAD_HOLD    = 60,    // 0..255
    parameter int unsigned SCORE_DIV    = 6      // 1..255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_animate,
    input  logic        i_collision,
    input  logic        i_start_btn,
    output logic [1:0]  o_game_state,
    output logic        o_round_rst,
    output logic [15:0] o_score,
    output logic [15:0] o_high_score
);

    typedef enum logic [1:0] {
        ST_DEAD    = 2'd0,
        ST_GRACE   = 2'd1,
        ST_PLAY    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_MIN   = 8'(DEAD_HOLD);
    localparam logic [7:0] GRACE_LAST = 8'(GRACE_FRAMES - 1);
    localparam logic [7:0] DIV_LAST   = 8'(SCORE_DIV - 1);

    state_t      state_q,      state_d;
    logic        round_rst_q,  round_rst_d;
    logic [15:0] score_q,      score_d;
    logic [15:0] high_q,       high_d;
    logic [7:0]  frame_cnt_q,  frame_cnt_d;
    logic [7:0]  presc_q,      presc_d;
    logic [7:0]  hold_q,       hold_d;
    logic        hit_flag_q,   hit_flag_d;
    logic        btn_sync1_q,  btn_sync1_d;
    logic        btn_sync2_q,  btn_sync2_d;
    logic        btn_prev_q,   btn_prev_d;
    logic        start_edge_q, start_edge_d;

    // A collision on the strobe cycle itself still belongs to the ending frame.
    logic frame_hit;
    assign frame_hit = hit_flag_q | i_collision;

    // BCD +1 as a ripple of per-digit carries; each digit wraps 9 -> 0 and
    // passes the carry up only when it wraps.
    logic [3:0]  carry;
    logic [15:0] score_inc;
    assign carry[0] = 1'b1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
        logic [3:0] digit;
        assign digit = score_q[gi*4 +: 4];
        assign score_inc[gi*4 +: 4] = !carry[gi]     ? digit :
                                      (digit == 4'd9) ? 4'd0  : digit + 4'd1;
        if (gi < 3) begin : g_carry
            assign carry[gi+1] = carry[gi] & (digit == 4'd9);
        end
    end

    // One frame of score progress: prescaler step, and a saturating BCD
    // increment whenever the prescaler wraps.
    logic        presc_wrap;
    logic [7:0]  presc_adv;
    logic [15:0] score_adv;
    assign presc_wrap = (presc_q == DIV_LAST);
    assign presc_adv  = presc_wrap ? 8'd0 : presc_q + 8'd1;
    assign score_adv  = !presc_wrap           ? score_q :
                        (score_q == 16'h9999) ? score_q : score_inc;

    always_comb begin
        // Button path: two synchronizer flops, then a registered rising edge.
        btn_sync1_d  = i_start_btn;
        btn_sync2_d  = btn_sync1_q;
        btn_prev_d   = btn_sync2_q;
        start_edge_d = btn_sync2_q & ~btn_prev_q;

        hit_flag_d   = i_animate ? 1'b0 : frame_hit;

        state_d      = state_q;
        round_rst_d  = 1'b0;
        score_d      = score_q;
        high_d       = high_q;
        frame_cnt_d  = frame_cnt_q;
        presc_d      = presc_q;
        hold_d       = hold_q;

        case (state_q)
            ST_DEAD: begin
                if (i_animate && hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
                // An early press is dropped, not remembered.
                if (start_edge_q && hold_q >= HOLD_MIN) begin
                    state_d     = ST_GRACE;
                    round_rst_d = 1'b1;
                    score_d     = 16'h0000;
                    frame_cnt_d = 8'd0;
                    presc_d     = 8'd0;
                end
            end
            ST_GRACE: begin
                if (i_animate) begin
                    presc_d = presc_adv;
                    score_d = score_adv;
                    if (frame_cnt_q == GRACE_LAST) begin
                        state_d     = ST_PLAY;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (i_animate) begin
                    if (frame_hit) begin
                        // The fatal frame earns no point; compare the
                        // pre-edge score (BCD orders like plain binary).
                        state_d = ST_DEAD;
                        hold_d  = 8'd0;
                        if (score_q > high_q) begin
                            high_d = score_q;
                        end
                    end else begin
                        presc_d = presc_adv;
                        score_d = score_adv;
                    end
                end
            end
            default: state_d = ST_DEAD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_DEAD;
            round_rst_q  <= 1'b0;
            score_q      <= 16'h0000;
            high_q       <= 16'h0000;
            frame_cnt_q  <= 8'd0;
            presc_q      <= 8'd0;
            hold_q       <= HOLD_MIN;   // first start accepted right away
            hit_flag_q   <= 1'b0;
            // Held high so a button pressed through reset gives no edge.
            btn_sync1_q  <= 1'b1;
            btn_sync2_q  <= 1'b1;
            btn_prev_q   <= 1'b1;
            start_edge_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_rst_q  <= round_rst_d;
            score_q      <= score_d;
            high_q       <= high_d;
            frame_cnt_q  <= frame_cnt_d;
            presc_q      <= presc_d;
            hold_q       <= hold_d;
            hit_flag_q   <= hit_flag_d;
            btn_sync1_q  <= btn_sync1_d;
            btn_sync2_q  <= btn_sync2_d;
            btn_prev_q   <= btn_prev_d;
            start_edge_q <= start_edge_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_DEAD:  o_game_state = DEAD_STATE;
            ST_GRACE: o_game_state = GRACE_STATE;
            ST_PLAY:  o_game_state = PLAY_STATE;
            default:  o_game_state = 2'd3;
        endcase
    end

    assign o_round_rst  = round_rst_q;
    assign o_score      = score_q;
    assign o_high_score = high_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_state_ctrl
//
// Random and directed stimulus for game_state_ctrl, checked every cycle
// against a behavioural model that keeps the score as a decimal integer and
// the button as a history of raw samples.
// -----------------------------------------------------------------------------
module tb_game_state_ctrl;

    localparam int GF = 3;      // grace frames
    localparam int DH = 60;     // dead hold frames
    localparam int SD = 2;      // frames per point
    localparam int S_DEAD  = 0;
    localparam int S_GRACE = 1;
    localparam int S_PLAY  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        animate = 1'b0;
    logic        collision = 1'b0;
    logic        start_btn = 1'b0;
    logic [1:0]  game_state;
    logic        round_rst;
    logic [15:0] score;
    logic [15:0] high_score;

    game_state_ctrl #(
        .DEAD_STATE   (2'd0),
        .GRACE_STATE  (2'd1),
        .PLAY_STATE   (2'd2),
        .GRACE_FRAMES (GF),
        .DEAD_HOLD    (DH),
        .SCORE_DIV    (SD)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_animate    (animate),
        .i_collision  (collision),
        .i_start_btn  (start_btn),
        .o_game_state (game_state),
        .o_round_rst  (round_rst),
        .o_score      (score),
        .o_high_score (high_score)
    );

    initial forever #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int rr_seen = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int       m_state, m_rr, m_score, m_high, m_frames, m_presc, m_hold;
    bit       m_flag;
    bit [3:0] m_raw;     // [0] = newest raw button sample

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_state = S_DEAD; m_rr = 0; m_score = 0; m_high = 0;
        m_frames = 0; m_presc = 0; m_hold = DH; m_flag = 0; m_raw = 4'b1111;
    endtask

    task automatic score_frame();
        m_presc++;
        if (m_presc == SD) begin
            m_presc = 0;
            if (m_score < 9999) m_score++;
        end
    endtask

    task automatic model_edge(input bit a, input bit c, input bit b);
        bit start, hit;
        // A press becomes visible to the state machine four edges after the
        // raw rise: sampled three edges ago high, four edges ago low.
        start  = m_raw[2] & ~m_raw[3];
        m_raw  = {m_raw[2:0], b};
        hit    = m_flag | c;
        m_flag = a ? 1'b0 : hit;
        m_rr   = 0;
        if (m_state == S_DEAD) begin
            if (start && m_hold >= DH) begin
                m_state = S_GRACE; m_rr = 1; m_score = 0; m_frames = 0; m_presc = 0;
                $display("round start t=%0t high=%0d", $time, m_high);
            end else if (a && m_hold < 255) begin
                m_hold++;
            end
        end else if (m_state == S_GRACE) begin
            if (a) begin
                score_frame();
                m_frames++;
                if (m_frames == GF) begin
                    m_state = S_PLAY; m_frames = 0;
                end
            end
        end else if (a) begin
            if (hit) begin
                m_state = S_DEAD; m_hold = 0;
                if (m_score > m_high) m_high = m_score;
                $display("death t=%0t score=%0d high=%0d", $time, m_score, m_high);
            end else begin
                score_frame();
            end
        end
    endtask

    // Called at a negedge: drive inputs, advance model at posedge, compare at
    // the next negedge.
    task automatic step(input bit a, input bit c, input bit b);
        animate = a; collision = c; start_btn = b;
        @(posedge clk);
        model_edge(a, c, b);
        @(negedge clk);
        if (round_rst) rr_seen++;
        chk("state", 16'(game_state), 16'(m_state));
        chk("round_rst", 16'(round_rst), 16'(m_rr));
        chk("score", score, to_bcd(m_score));
        chk("high", high_score, to_bcd(m_high));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", 16'(game_state), 16'(S_DEAD));
        chk("rst_rr", 16'(round_rst), 16'd0);
        chk("rst_score", score, 16'h0000);
        chk("rst_high", high_score, 16'h0000);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // From anywhere: die, wait out the hold, press start, reach PLAY while
    // colliding every grace frame.
    task automatic restart_round();
        for (int i = 0; i < 100 && m_state != S_DEAD; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < DH + 1; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && m_state != S_PLAY; i++)
            step(1'b1, bit'(m_state == S_GRACE), 1'b0);
        chk("play_reached", 16'(game_state), 16'(S_PLAY));
    endtask

    initial begin
        bit b;
        model_reset();
        #1;
        chk("rst_state", 16'(game_state), 16'(S_DEAD));
        chk("rst_score", score, 16'h0000);
        chk("rst_high", high_score, 16'h0000);
        chk("rst_rr", 16'(round_rst), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Start latency: pulse lands on the fourth edge after the raw rise.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("rr_latency", 16'(round_rst), 16'(k == 4));
        end
        chk("start_state", 16'(game_state), 16'(S_GRACE));
        chk("start_score", score, 16'h0000);

        // Random play.
        b = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) b = ~b;
            step(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 39) == 0), b);
        end

        // Long round to saturation, then a short one that must not lower it.
        restart_round();
        for (int i = 0; i < 20100 && m_score != 9999; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        chk("sat_score", score, 16'h9999);
        step(1'b1, 1'b1, 1'b0);
        chk("sat_high", high_score, 16'h9999);
        restart_round();
        for (int i = 0; i < 200 && m_score != 42; i++) step(1'b1, 1'b0, 1'b0);
        chk("score_42", score, 16'h0042);
        step(1'b1, 1'b1, 1'b0);
        chk("high_kept", high_score, 16'h9999);
        chk("dead_42", 16'(game_state), 16'(S_DEAD));

        // Hold window: press at 10 frames ignored, press at 60 accepted.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        rr_seen = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        chk("early_pulses", 16'(rr_seen), 16'd0);
        chk("early_state", 16'(game_state), 16'(S_DEAD));
        for (int i = 0; i < DH - 10; i++) step(1'b1, 1'b0, 1'b0);
        rr_seen = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        chk("late_pulses", 16'(rr_seen), 16'd1);
        chk("late_state", 16'(game_state), 16'(S_GRACE));

        // Collision long before the strobe, then collision on the strobe.
        for (int i = 0; i < 10 && m_state != S_PLAY; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 99; i++) step(1'b0, 1'b0, 1'b0);
        chk("latched_alive", 16'(game_state), 16'(S_PLAY));
        step(1'b1, 1'b0, 1'b0);
        chk("latched_hit", 16'(game_state), 16'(S_DEAD));
        restart_round();
        step(1'b1, 1'b1, 1'b0);
        chk("strobe_hit", 16'(game_state), 16'(S_DEAD));

        // Reset in the middle of a round.
        restart_round();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        do_reset();

        // Button held across reset release: no start even though hold is met.
        start_btn = 1'b1;
        do_reset();
        rr_seen = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
        chk("held_pulses", 16'(rr_seen), 16'd0);
        chk("held_state", 16'(game_state), 16'(S_DEAD));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
